// File: rtl/multichannel_section_peak_to_peak_if.sv
`default_nettype none
// ============================================================================
// Module      : multichannel_section_peak_to_peak_if
// Description : Sample-in / result-out handshake bundle for the multichannel
//               section peak-to-peak block.
//               master = upstream/downstream side, slave = the block itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface multichannel_section_peak_to_peak_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2
);
  localparam int c_CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic              i_valid;
  logic              i_ready;
  logic [c_CW-1:0]   i_channel;
  logic [WIDTH-1:0]  i_value;
  logic              o_valid;
  logic              o_ready;
  logic [c_CW-1:0]   o_channel;
  logic [WIDTH-1:0]  o_value;

  modport master (
    output i_valid, i_channel, i_value, o_ready,
    input  i_ready, o_valid, o_channel, o_value
  );

  modport slave (
    input  i_valid, i_channel, i_value, o_ready,
    output i_ready, o_valid, o_channel, o_value
  );
endinterface
`default_nettype wire

// File: rtl/multichannel_section_peak_to_peak.sv
`default_nettype none
// ============================================================================
// Module      : multichannel_section_peak_to_peak
// Description : Per-channel section min/max tracking with a history ring of
//               section extremes; emits the channel peak-to-peak value after
//               every completed section.
//               Optional macro PEAK_HOLD_EN adds a per-channel peak hold.
// Revision    : 1.0 - initial release
// ============================================================================
module multichannel_section_peak_to_peak #(
  parameter int WIDTH         = 16,
  parameter int CHANNELS      = 2,
  parameter int SAMPLE_COUNT  = 4,
  parameter int BUFFER_DEPTH  = 4,
  parameter int HOLD_SECTIONS = 2
) (
  input wire clk,
  input wire reset,
  multichannel_section_peak_to_peak_if.slave bus
);
  localparam int c_CW = (CHANNELS > 1)     ? $clog2(CHANNELS)     : 1;
  localparam int c_SW = (SAMPLE_COUNT > 1) ? $clog2(SAMPLE_COUNT) : 1;
  localparam int c_BW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam logic [c_SW-1:0] c_LAST_SAMPLE = c_SW'(SAMPLE_COUNT - 1);
  localparam logic [c_BW-1:0] c_LAST_ENTRY  = c_BW'(BUFFER_DEPTH - 1);
  localparam logic [c_CW:0]   c_NUM_CH      = (c_CW + 1)'(CHANNELS);

  localparam logic [1:0] c_ST_RST  = 2'd0;
  localparam logic [1:0] c_ST_IDLE = 2'd1;
  localparam logic [1:0] c_ST_SCAN = 2'd2;
  localparam logic [1:0] c_ST_OUT  = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;

  logic [c_SW-1:0]   r_cnt     [CHANNELS];
  logic [WIDTH-1:0]  r_acc_min [CHANNELS];
  logic [WIDTH-1:0]  r_acc_max [CHANNELS];
  logic [WIDTH-1:0]  r_ring_min [CHANNELS][BUFFER_DEPTH];
  logic [WIDTH-1:0]  r_ring_max [CHANNELS][BUFFER_DEPTH];
  logic [BUFFER_DEPTH-1:0] r_ring_vld [CHANNELS];
  logic [c_BW-1:0]   r_wr_ptr  [CHANNELS];

  logic [c_CW-1:0]   r_ch;
  logic [c_BW-1:0]   r_scan_idx;
  logic [WIDTH-1:0]  r_scan_min;
  logic [WIDTH-1:0]  r_scan_max;
  logic [c_CW-1:0]   r_o_channel;
  logic [WIDTH-1:0]  r_o_value;

  // Sample acceptance and section folding for the tagged channel
  logic              w_take;
  logic              w_first;
  logic              w_final;
  logic [WIDTH-1:0]  w_sec_min;
  logic [WIDTH-1:0]  w_sec_max;

  assign w_take    = (r_state == c_ST_IDLE) && bus.i_valid && ({1'b0, bus.i_channel} < c_NUM_CH);
  assign w_first   = (r_cnt[bus.i_channel] == '0);
  assign w_final   = w_take && (r_cnt[bus.i_channel] == c_LAST_SAMPLE);
  assign w_sec_min = (w_first || bus.i_value < r_acc_min[bus.i_channel]) ? bus.i_value : r_acc_min[bus.i_channel];
  assign w_sec_max = (w_first || bus.i_value > r_acc_max[bus.i_channel]) ? bus.i_value : r_acc_max[bus.i_channel];

  // Ring scan: fold one entry per cycle, skipping entries never written
  logic              w_ent_vld;
  logic              w_scan_last;
  logic [WIDTH-1:0]  w_fold_min;
  logic [WIDTH-1:0]  w_fold_max;
  logic [WIDTH-1:0]  w_cur;
  logic [WIDTH-1:0]  w_out;

  assign w_ent_vld   = r_ring_vld[r_ch][r_scan_idx];
  assign w_scan_last = (r_scan_idx == c_LAST_ENTRY);
  assign w_fold_min  = (w_ent_vld && r_ring_min[r_ch][r_scan_idx] < r_scan_min) ? r_ring_min[r_ch][r_scan_idx] : r_scan_min;
  assign w_fold_max  = (w_ent_vld && r_ring_max[r_ch][r_scan_idx] > r_scan_max) ? r_ring_max[r_ch][r_scan_idx] : r_scan_max;
  // The newest entry is always valid, so fold_max >= fold_min here
  assign w_cur       = w_fold_max - w_fold_min;

`ifdef PEAK_HOLD_EN
  localparam int c_HW = (HOLD_SECTIONS > 0) ? $clog2(HOLD_SECTIONS + 1) : 1;
  logic [WIDTH-1:0]  r_held     [CHANNELS];
  logic [c_HW-1:0]   r_hold_cnt [CHANNELS];
  logic              w_reload;

  assign w_reload = (w_cur >= r_held[r_ch]) || (r_hold_cnt[r_ch] == '0);
  assign w_out    = w_reload ? w_cur : r_held[r_ch];

  // Peak hold: refresh on a new higher peak or when the hold expires
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_held[c]     <= '0;
        r_hold_cnt[c] <= '0;
      end
    end else if (r_state == c_ST_SCAN && w_scan_last) begin
      if (w_reload) begin
        r_held[r_ch]     <= w_cur;
        r_hold_cnt[r_ch] <= c_HW'(HOLD_SECTIONS);
      end else begin
        r_hold_cnt[r_ch] <= r_hold_cnt[r_ch] - 1'b1;
      end
    end
  end
`else
  assign w_out = w_cur;
`endif

  // State register; the reset state keeps i_ready low until the first edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_ST_RST;
    else        r_state <= w_next_state;
  end

  // Next-state selection
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_RST:  w_next_state = c_ST_IDLE;
      c_ST_IDLE: if (w_final)     w_next_state = c_ST_SCAN;
      c_ST_SCAN: if (w_scan_last) w_next_state = c_ST_OUT;
      c_ST_OUT:  if (bus.o_ready) w_next_state = c_ST_IDLE;
      default:   w_next_state = c_ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    bus.i_ready = (r_state == c_ST_IDLE);
    bus.o_valid = (r_state == c_ST_OUT);
  end

  assign bus.o_channel = r_o_channel;
  assign bus.o_value   = r_o_value;

  // Datapath: accumulate sections, commit to ring, scan ring, latch result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_cnt[c]      <= '0;
        r_acc_min[c]  <= '0;
        r_acc_max[c]  <= '0;
        r_ring_vld[c] <= '0;
        r_wr_ptr[c]   <= '0;
        for (int e = 0; e < BUFFER_DEPTH; e++) begin
          r_ring_min[c][e] <= '0;
          r_ring_max[c][e] <= '0;
        end
      end
      r_ch        <= '0;
      r_scan_idx  <= '0;
      r_scan_min  <= '0;
      r_scan_max  <= '0;
      r_o_channel <= '0;
      r_o_value   <= '0;
    end else begin
      if (w_take) begin
        if (w_final) begin
          r_ring_min[bus.i_channel][r_wr_ptr[bus.i_channel]] <= w_sec_min;
          r_ring_max[bus.i_channel][r_wr_ptr[bus.i_channel]] <= w_sec_max;
          r_ring_vld[bus.i_channel][r_wr_ptr[bus.i_channel]] <= 1'b1;
          r_wr_ptr[bus.i_channel] <= (r_wr_ptr[bus.i_channel] == c_LAST_ENTRY) ? '0 : r_wr_ptr[bus.i_channel] + 1'b1;
          r_cnt[bus.i_channel]     <= '0;
          r_acc_min[bus.i_channel] <= '0;
          r_acc_max[bus.i_channel] <= '0;
          r_ch       <= bus.i_channel;
          r_scan_idx <= '0;
          r_scan_min <= '1;
          r_scan_max <= '0;
        end else begin
          r_cnt[bus.i_channel]     <= r_cnt[bus.i_channel] + 1'b1;
          r_acc_min[bus.i_channel] <= w_sec_min;
          r_acc_max[bus.i_channel] <= w_sec_max;
        end
      end
      if (r_state == c_ST_SCAN) begin
        r_scan_min <= w_fold_min;
        r_scan_max <= w_fold_max;
        r_scan_idx <= r_scan_idx + 1'b1;
        if (w_scan_last) begin
          r_o_channel <= r_ch;
          r_o_value   <= w_out;
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_multichannel_section_peak_to_peak.sv
`default_nettype none
// ============================================================================
// Module      : tb_multichannel_section_peak_to_peak
// Description : Directed bench. Instance A: 2 channels, depth 4.
//               Instance B: 3 channels, depth 1, hold 2 (PEAK_HOLD_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multichannel_section_peak_to_peak;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  multichannel_section_peak_to_peak_if #(.WIDTH(16), .CHANNELS(2)) ifa ();
  multichannel_section_peak_to_peak_if #(.WIDTH(16), .CHANNELS(3)) ifb ();

  multichannel_section_peak_to_peak #(
    .WIDTH(16), .CHANNELS(2), .SAMPLE_COUNT(4), .BUFFER_DEPTH(4), .HOLD_SECTIONS(2)
  ) u_dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));

  multichannel_section_peak_to_peak #(
    .WIDTH(16), .CHANNELS(3), .SAMPLE_COUNT(4), .BUFFER_DEPTH(1), .HOLD_SECTIONS(2)
  ) u_dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  function automatic logic f_ir(int sel);
    return (sel == 0) ? ifa.i_ready : ifb.i_ready;
  endfunction
  function automatic logic f_ov(int sel);
    return (sel == 0) ? ifa.o_valid : ifb.o_valid;
  endfunction
  function automatic logic [31:0] f_oc(int sel);
    return (sel == 0) ? {31'd0, ifa.o_channel} : {30'd0, ifb.o_channel};
  endfunction
  function automatic logic [31:0] f_val(int sel);
    return (sel == 0) ? {16'd0, ifa.o_value} : {16'd0, ifb.o_value};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(int sel, logic v, logic [1:0] ch, logic [15:0] val);
    if (sel == 0) begin
      ifa.i_valid = v; ifa.i_channel = ch[0]; ifa.i_value = val;
    end else begin
      ifb.i_valid = v; ifb.i_channel = ch; ifb.i_value = val;
    end
  endtask

  // Present one sample and wait (bounded) for it to be accepted
  task automatic send(int sel, logic [1:0] ch, logic [15:0] val);
    int n = 0;
    @(negedge clk);
    drive(sel, 1'b1, ch, val);
    while (!f_ir(sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, ch, val);
  endtask

  task automatic send4(int sel, logic [1:0] ch, logic [15:0] val);
    for (int i = 0; i < 4; i++) send(sel, ch, val);
  endtask

  // Called right after the accepting edge of a final sample; o_ready assumed 1
  task automatic get_result(int sel, logic [1:0] ch, logic [15:0] val, string tag);
    int d = (sel == 0) ? 4 : 1;
    for (int k = 1; k < d; k++) begin
      @(posedge clk); #1;
      chk({tag, "_early_valid"}, {31'd0, f_ov(sel)}, 32'd0);
    end
    @(posedge clk); #1;
    chk({tag, "_valid"}, {31'd0, f_ov(sel)}, 32'd1);
    chk({tag, "_chan"},  f_oc(sel), {30'd0, ch});
    chk({tag, "_value"}, f_val(sel), {16'd0, val});
    @(posedge clk); #1;
    chk({tag, "_done"},  {31'd0, f_ov(sel)}, 32'd0);
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk({tag, "_rst_iready"}, {31'd0, ifa.i_ready}, 32'd0);
    chk({tag, "_rst_ovalid"}, {31'd0, ifa.o_valid}, 32'd0);
    chk({tag, "_rst_ochan"},  f_oc(0), 32'd0);
    chk({tag, "_rst_ovalue"}, f_val(0), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_post_iready"}, {31'd0, ifa.i_ready}, 32'd1);
  endtask

  logic [15:0] exp6 [4];

  initial begin
`ifdef PEAK_HOLD_EN
    exp6[0] = 16'hFFFF; exp6[1] = 16'hFFFF; exp6[2] = 16'hFFFF; exp6[3] = 16'h0000;
`else
    exp6[0] = 16'hFFFF; exp6[1] = 16'h0000; exp6[2] = 16'h0000; exp6[3] = 16'h0000;
`endif
    drive(0, 1'b0, 2'd0, 16'h0);
    drive(1, 1'b0, 2'd0, 16'h0);
    ifa.o_ready = 1'b1;
    ifb.o_ready = 1'b1;

    // 1: reset state, first single-section result
    do_reset("t1");
    send4(0, 2'd0, 16'h1111);
    get_result(0, 2'd0, 16'h0000, "t1");

    // 2: ring fill and wrap on channel 0
    send4(0, 2'd0, 16'h2222); get_result(0, 2'd0, 16'h1111, "t2a");
    send4(0, 2'd0, 16'h3333); get_result(0, 2'd0, 16'h2222, "t2b");
    send4(0, 2'd0, 16'h4444); get_result(0, 2'd0, 16'h3333, "t2c");
    send4(0, 2'd0, 16'h5555); get_result(0, 2'd0, 16'h3333, "t2d");

    // 3: interleaved channels from a clean state
    do_reset("t3");
    send(0, 2'd0, 16'h0100); send(0, 2'd1, 16'h1000);
    send(0, 2'd0, 16'h0100); send(0, 2'd1, 16'h3000);
    send(0, 2'd0, 16'h0100); send(0, 2'd1, 16'h2000);
    send(0, 2'd0, 16'h0100);
    get_result(0, 2'd0, 16'h0000, "t3_ch0");
    send(0, 2'd1, 16'h4000);
    get_result(0, 2'd1, 16'h3000, "t3_ch1");

    // 4: backpressure holds the result stable
    @(negedge clk);
    ifa.o_ready = 1'b0;
    send4(0, 2'd1, 16'h0500);
    repeat (4) @(posedge clk);
    #1;
    chk("t4_valid", {31'd0, ifa.o_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("t4_hold_valid",  {31'd0, ifa.o_valid}, 32'd1);
      chk("t4_hold_value",  f_val(0), 32'h3B00);
      chk("t4_hold_chan",   f_oc(0), 32'd1);
      chk("t4_hold_iready", {31'd0, ifa.i_ready}, 32'd0);
    end
    @(negedge clk);
    ifa.o_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_release_valid",  {31'd0, ifa.o_valid}, 32'd0);
    chk("t4_release_iready", {31'd0, ifa.i_ready}, 32'd1);

    // 5: reset discards a partial section and the ring
    send(0, 2'd0, 16'h9999);
    send(0, 2'd0, 16'h9999);
    do_reset("t5");
    send4(0, 2'd0, 16'h7777);
    get_result(0, 2'd0, 16'h0000, "t5");

    // 5b: out-of-range channel tag is dropped (3-channel instance)
    send4(1, 2'd3, 16'hFFFF);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("t5_drop_ovalid", {31'd0, ifb.o_valid}, 32'd0);
    end
    chk("t5_drop_iready", {31'd0, ifb.i_ready}, 32'd1);

    // 6: depth-1 ring, peak hold behaviour depends on build
    send(1, 2'd0, 16'h0000); send(1, 2'd0, 16'hFFFF);
    send(1, 2'd0, 16'h0000); send(1, 2'd0, 16'hFFFF);
    get_result(1, 2'd0, exp6[0], "t6_0");
    send4(1, 2'd0, 16'h5555); get_result(1, 2'd0, exp6[1], "t6_1");
    send4(1, 2'd0, 16'h5555); get_result(1, 2'd0, exp6[2], "t6_2");
    send4(1, 2'd0, 16'h5555); get_result(1, 2'd0, exp6[3], "t6_3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
